// File: rtl/srio_seg_planner.sv
// Splits one SRIO TX transfer request into max-payload segments followed by a single
// power-of-two rounded tail segment, one descriptor per downstream handshake.
module srio_seg_planner #(
   parameter int LEN_W        = 20,
   parameter int ADDR_W       = 34,
   parameter int MAX_PLD_LOG2 = 8,
   parameter int MIN_PLD_LOG2 = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [LEN_W-1:0]              req_len,
   input  logic [ADDR_W-1:0]             req_addr,
   output logic                          seg_valid,
   input  logic                          seg_ready,
   output logic [ADDR_W-1:0]             seg_addr,
   output logic [MAX_PLD_LOG2:0]         seg_size,
   output logic [MAX_PLD_LOG2:0]         seg_bytes,
   output logic [MAX_PLD_LOG2-1:0]       seg_pad,
   output logic                          seg_last,
   output logic [LEN_W-MAX_PLD_LOG2-1:0] seg_idx,
   output logic                          busy
);

   localparam int                    IDX_W     = LEN_W - MAX_PLD_LOG2;
   localparam logic [MAX_PLD_LOG2:0] FULL_SZ   = {1'b1, {MAX_PLD_LOG2{1'b0}}};
   localparam logic [ADDR_W-1:0]     ADDR_STEP = ADDR_W'(FULL_SZ);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  state;
   logic [IDX_W-1:0]        full_cnt;
   logic [MAX_PLD_LOG2:0]   tail_size_q;
   logic [MAX_PLD_LOG2:0]   tail_bytes_q;
   logic [MAX_PLD_LOG2:0]   tail_bytes;
   logic [MAX_PLD_LOG2:0]   tail_size;
   logic [IDX_W-1:0]        next_idx;

   // Tail rounding: scanning sizes from largest to smallest leaves the smallest fit.
   always_comb begin
      tail_bytes = {1'b0, req_len[MAX_PLD_LOG2-1:0]} + (MAX_PLD_LOG2+1)'(1);
      tail_size  = FULL_SZ;
      for (int k = MAX_PLD_LOG2; k >= MIN_PLD_LOG2; k--) begin
         if ((FULL_SZ >> (MAX_PLD_LOG2 - k)) >= tail_bytes) begin
            tail_size = FULL_SZ >> (MAX_PLD_LOG2 - k);
         end
      end
      next_idx = seg_idx + IDX_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         req_ready    <= 1'b0;
         seg_valid    <= 1'b0;
         busy         <= 1'b0;
         seg_addr     <= '0;
         seg_size     <= '0;
         seg_bytes    <= '0;
         seg_pad      <= '0;
         seg_last     <= 1'b0;
         seg_idx      <= '0;
         full_cnt     <= '0;
         tail_size_q  <= '0;
         tail_bytes_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  state        <= EMIT;
                  req_ready    <= 1'b0;
                  seg_valid    <= 1'b1;
                  busy         <= 1'b1;
                  seg_addr     <= req_addr;
                  seg_idx      <= '0;
                  full_cnt     <= req_len[LEN_W-1:MAX_PLD_LOG2];
                  tail_size_q  <= tail_size;
                  tail_bytes_q <= tail_bytes;
                  if (req_len[LEN_W-1:MAX_PLD_LOG2] == '0) begin
                     seg_size  <= tail_size;
                     seg_bytes <= tail_bytes;
                     seg_pad   <= MAX_PLD_LOG2'(tail_size - tail_bytes);
                     seg_last  <= 1'b1;
                  end else begin
                     seg_size  <= FULL_SZ;
                     seg_bytes <= FULL_SZ;
                     seg_pad   <= '0;
                     seg_last  <= 1'b0;
                  end
               end
            end
            EMIT: begin
               // Descriptor fields only move on a handshake, so stalls hold them stable.
               if (seg_ready) begin
                  if (seg_last) begin
                     state     <= IDLE;
                     seg_valid <= 1'b0;
                     busy      <= 1'b0;
                     req_ready <= 1'b1;
                  end else begin
                     seg_idx  <= next_idx;
                     seg_addr <= seg_addr + ADDR_STEP;
                     if (next_idx == full_cnt) begin
                        seg_size  <= tail_size_q;
                        seg_bytes <= tail_bytes_q;
                        seg_pad   <= MAX_PLD_LOG2'(tail_size_q - tail_bytes_q);
                        seg_last  <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_srio_seg_planner.sv
// Self-checking bench for srio_seg_planner: directed vector table, randomized transfers
// against an arithmetic segment model, stall/reset sequences and a MAX_PLD_LOG2=6 instance.
module tb_srio_seg_planner;

   typedef struct packed {
      logic [33:0] addr;
      logic [8:0]  size;
      logic [8:0]  bytes;
      logic [7:0]  pad;
      logic        last;
      logic [11:0] idx;
   } seg_t;

   typedef struct {
      logic [19:0] len;
      logic [33:0] addr;
      int          mode;
      int          nseg;
      longint      tsize;
      longint      tbytes;
      longint      tpad;
      longint      taddr;
      longint      tidx;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, seg_valid, seg_ready, seg_last, busy;
   logic [19:0] req_len;
   logic [33:0] req_addr, seg_addr;
   logic [8:0]  seg_size, seg_bytes;
   logic [7:0]  seg_pad;
   logic [11:0] seg_idx;

   logic        req6_valid, req6_ready, seg6_valid, seg6_ready, seg6_last, busy6;
   logic [19:0] req6_len;
   logic [33:0] req6_addr, seg6_addr;
   logic [6:0]  seg6_size, seg6_bytes;
   logic [5:0]  seg6_pad;
   logic [13:0] seg6_idx;

   int   passCount = 0;
   int   checkCount = 0;
   seg_t expQ[$];

   always #5 clk = ~clk;

   srio_seg_planner dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_len(req_len), .req_addr(req_addr), .seg_valid(seg_valid), .seg_ready(seg_ready),
      .seg_addr(seg_addr), .seg_size(seg_size), .seg_bytes(seg_bytes), .seg_pad(seg_pad),
      .seg_last(seg_last), .seg_idx(seg_idx), .busy(busy)
   );

   srio_seg_planner #(.MAX_PLD_LOG2(6)) dut6 (
      .clk(clk), .reset(reset), .req_valid(req6_valid), .req_ready(req6_ready),
      .req_len(req6_len), .req_addr(req6_addr), .seg_valid(seg6_valid), .seg_ready(seg6_ready),
      .seg_addr(seg6_addr), .seg_size(seg6_size), .seg_bytes(seg6_bytes), .seg_pad(seg6_pad),
      .seg_last(seg6_last), .seg_idx(seg6_idx), .busy(busy6)
   );

   task automatic checkOutput(input string name, input longint unsigned act, input longint unsigned exp);
      checkCount++;
      if (act == exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic checkSeg(input string name, input seg_t act, input seg_t exp);
      checkCount++;
      if (act == exp) passCount++;
      else $display("[TB] FAIL %s: got addr=%0h size=%0d bytes=%0d pad=%0d last=%0d idx=%0d, expected addr=%0h size=%0d bytes=%0d pad=%0d last=%0d idx=%0d",
                    name, act.addr, act.size, act.bytes, act.pad, act.last, act.idx,
                    exp.addr, exp.size, exp.bytes, exp.pad, exp.last, exp.idx);
   endtask

   // Model: ceil(bytes/256) segments, all full except the tail, tail padded up to a power of two >= 8.
   function automatic void buildModel(input logic [19:0] lenv, input logic [33:0] addrv);
      longint total = longint'(lenv) + 1;
      longint nseg  = (total + 255) / 256;
      for (longint i = 0; i < nseg; i++) begin
         seg_t   e;
         longint b = (i == nseg - 1) ? total - (nseg - 1) * 256 : 256;
         longint s = 8;
         while (s < b) s = s * 2;
         e.addr  = 34'(longint'(addrv) + i * 256);
         e.size  = 9'(s);
         e.bytes = 9'(b);
         e.pad   = 8'(s - b);
         e.last  = (i == nseg - 1);
         e.idx   = 12'(i);
         expQ.push_back(e);
      end
   endfunction

   function automatic seg_t sampleSeg();
      seg_t c;
      c.addr = seg_addr; c.size = seg_size; c.bytes = seg_bytes;
      c.pad = seg_pad; c.last = seg_last; c.idx = seg_idx;
      return c;
   endfunction

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready plus ignored requests while busy
   task automatic applyStimulus(input logic [19:0] lenv, input logic [33:0] addrv, input int mode,
                                output seg_t tail, output int nseg);
      int   t = 0;
      int   cyc = 0;
      int   pat = 0;
      int   limit;
      bit   stalled = 0;
      bit   rdy;
      seg_t held, cur;
      buildModel(lenv, addrv);
      limit = expQ.size() * 8 + 50;
      nseg = 0;
      tail = '0;
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      checkOutput("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_len = lenv; req_addr = addrv;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("zero_bubble_valid", seg_valid, 1);
      while (expQ.size() > 0 && cyc < limit) begin
         if (!seg_valid) begin
            checkOutput("seg_valid_mid_transfer", seg_valid, 1);
            break;
         end
         cur = sampleSeg();
         if (stalled) checkSeg("stall_stable", cur, held);
         checkSeg("descriptor", cur, expQ[0]);
         case (mode)
            1:       rdy = (pat % 4 == 0) || (pat % 4 == 3);
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b1;
         endcase
         pat++;
         seg_ready = rdy;
         if (mode == 2) begin
            req_valid = 1'($urandom_range(0, 1));
            req_len   = 20'($urandom);
         end
         if (rdy) begin
            void'(expQ.pop_front());
            tail = cur;
            nseg++;
            stalled = 0;
            if (cur.last) req_valid = 1'b0;
         end else begin
            stalled = 1;
            held = cur;
         end
         @(negedge clk);
         cyc++;
      end
      if (expQ.size() != 0) begin
         checkOutput("transfer_complete_in_budget", expQ.size(), 0);
         expQ.delete();
      end
      req_valid = 1'b0;
      seg_ready = 1'b0;
      checkOutput("req_ready_after_last", req_ready, 1);
      checkOutput("seg_valid_after_last", seg_valid, 0);
      checkOutput("busy_after_last", busy, 0);
   endtask

   initial begin
      vec_t vecs[$];
      seg_t tail;
      int   nseg;
      int   t;
      logic [31:0] r;

      vecs.push_back('{20'd0,     34'h1000, 0, 1, 8,   1,   7,  34'h1000, 0});
      vecs.push_back('{20'd255,   34'h2000, 0, 1, 256, 256, 0,  34'h2000, 0});
      vecs.push_back('{20'd256,   34'h0,    0, 2, 8,   1,   7,  34'h100,  1});
      vecs.push_back('{20'h3FF,   34'h0,    1, 4, 256, 256, 0,  34'h300,  3});
      vecs.push_back('{20'd40,    34'h500,  0, 1, 64,  41,  23, 34'h500,  0});
      vecs.push_back('{20'd8,     34'h40,   2, 1, 16,  9,   7,  34'h40,   0});
      vecs.push_back('{20'h1FF,   34'h3_FFFF_FF80, 0, 2, 256, 256, 0, 34'h80, 1});

      reset = 1'b1;
      req_valid = 1'b0; req_len = '0; req_addr = '0; seg_ready = 1'b0;
      req6_valid = 1'b0; req6_len = '0; req6_addr = '0; seg6_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", req_ready, 0);
      checkOutput("reset_seg_valid", seg_valid, 0);
      checkOutput("reset_busy", busy, 0);
      checkSeg("reset_seg_fields", sampleSeg(), '0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("req_ready_after_reset", req_ready, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].len, vecs[i].addr, vecs[i].mode, tail, nseg);
         checkOutput($sformatf("vec%0d_nseg", i), nseg, vecs[i].nseg);
         checkOutput($sformatf("vec%0d_tail_size", i), tail.size, vecs[i].tsize);
         checkOutput($sformatf("vec%0d_tail_bytes", i), tail.bytes, vecs[i].tbytes);
         checkOutput($sformatf("vec%0d_tail_pad", i), tail.pad, vecs[i].tpad);
         checkOutput($sformatf("vec%0d_tail_addr", i), tail.addr, vecs[i].taddr);
         checkOutput($sformatf("vec%0d_tail_idx", i), tail.idx, vecs[i].tidx);
      end

      for (int l = 0; l < 256; l++) begin
         r = $urandom;
         applyStimulus(20'(l), {r[1:0], 32'($urandom)}, 0, tail, nseg);
      end

      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         applyStimulus(20'($urandom_range(0, 20'hFFF)), {r[1:0], 32'($urandom)}, 2, tail, nseg);
      end

      applyStimulus(20'hFFFFF, 34'h3_FFFF_FF00, 0, tail, nseg);
      checkOutput("max_req_nseg", nseg, 4096);
      checkOutput("max_req_tail_idx", tail.idx, 12'hFFF);

      // Reset mid-transfer discards the transfer; the next request starts clean.
      t = 0;
      while (!req_ready && t < 50) begin @(negedge clk); t++; end
      req_valid = 1'b1; req_len = 20'h2FF; req_addr = 34'h8000;
      @(negedge clk);
      req_valid = 1'b0; seg_ready = 1'b1;
      @(negedge clk);
      checkOutput("pre_reset_idx", seg_idx, 1);
      reset = 1'b1;
      #1;
      checkOutput("mid_reset_seg_valid", seg_valid, 0);
      checkOutput("mid_reset_busy", busy, 0);
      checkOutput("mid_reset_req_ready", req_ready, 0);
      @(negedge clk);
      reset = 1'b0; seg_ready = 1'b0;
      @(negedge clk);
      applyStimulus(20'd7, 34'h80, 0, tail, nseg);
      checkOutput("post_reset_nseg", nseg, 1);
      checkOutput("post_reset_size", tail.size, 8);
      checkOutput("post_reset_pad", tail.pad, 0);
      checkOutput("post_reset_idx", tail.idx, 0);

      // 64-byte max payload instance: 101 bytes -> 64 full + 37 byte tail padded to 64.
      t = 0;
      while (!req6_ready && t < 50) begin @(negedge clk); t++; end
      req6_valid = 1'b1; req6_len = 20'd100; req6_addr = 34'h0;
      @(negedge clk);
      req6_valid = 1'b0;
      checkOutput("p6_first_valid", seg6_valid, 1);
      checkOutput("p6_first_size", seg6_size, 64);
      checkOutput("p6_first_bytes", seg6_bytes, 64);
      checkOutput("p6_first_pad", seg6_pad, 0);
      checkOutput("p6_first_last", seg6_last, 0);
      @(negedge clk);
      checkOutput("p6_tail_addr", seg6_addr, 34'h40);
      checkOutput("p6_tail_size", seg6_size, 64);
      checkOutput("p6_tail_bytes", seg6_bytes, 37);
      checkOutput("p6_tail_pad", seg6_pad, 27);
      checkOutput("p6_tail_last", seg6_last, 1);
      checkOutput("p6_tail_idx", seg6_idx, 1);
      @(negedge clk);
      checkOutput("p6_req_ready_after", req6_ready, 1);
      checkOutput("p6_valid_after", seg6_valid, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/srio_seg_planner.md
Name: srio_seg_planner

Overview:
- Sequential transfer segmenter for the SRIO TX path.
- Accepts one transfer request (byte length minus one, plus base address) and emits one segment descriptor per handshake: full max-payload segments first, then exactly one tail segment.
- The tail is rounded up to the smallest supported power-of-two payload, and its pad byte count is reported.
- The maximum payload, minimum payload and the length/address widths are parameters. The block feeds the NWRITE/SWRITE packet builder.

Parameters:
- LEN_W, 20, request length width (bytes minus one)
- ADDR_W, 34, SRIO address width
- MAX_PLD_LOG2, 8, log2 of maximum segment payload in bytes (legal 3..8)
- MIN_PLD_LOG2, 3, log2 of minimum supported payload (legal 3..MAX_PLD_LOG2)

Ports:
- clk  in  1  block clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_len  in  LEN_W  transfer bytes minus one
- req_addr  in  ADDR_W  transfer base address
- seg_valid  out  1  descriptor valid
- seg_ready  in  1  downstream accepts descriptor
- seg_addr  out  ADDR_W  segment start address
- seg_size  out  MAX_PLD_LOG2+1  rounded segment payload in bytes (full value; 256 is representable)
- seg_bytes  out  MAX_PLD_LOG2+1  real data bytes in segment
- seg_pad  out  MAX_PLD_LOG2  pad bytes = seg_size - seg_bytes
- seg_last  out  1  tail segment of the transfer
- seg_idx  out  LEN_W-MAX_PLD_LOG2  segment index within the transfer, from 0
- busy  out  1  transfer in progress

Behaviour:
- Reset values:
  - Outputs: req_ready=0 while reset is asserted, then 1 in IDLE; seg_valid=0; busy=0; all seg_* fields=0.
  - Internal: state=IDLE; counters=0.
- Length decomposition on request accept:
  - full_cnt = req_len[LEN_W-1:MAX_PLD_LOG2]
  - rem = req_len[MAX_PLD_LOG2-1:0]
  - Total segments = full_cnt + 1. The tail is always emitted.
- Tail rounding:
  - tail_bytes = rem + 1.
  - tail_size = smallest 2^k with k in [MIN_PLD_LOG2, MAX_PLD_LOG2] and 2^k >= tail_bytes.
  - seg_pad = tail_size - tail_bytes.
- Full segments: seg_size = seg_bytes = 2^MAX_PLD_LOG2, seg_pad = 0, seg_last = 0.
- Address:
  - Segment i address = req_addr + i*2^MAX_PLD_LOG2, computed by accumulation, not multiplication.
  - Wraps modulo 2^ADDR_W with no error flag.
- FSM:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch full_cnt, rem and address; go to EMIT.
  - EMIT: seg_valid=1, req_ready=0, busy=1.
    - On seg_valid&&seg_ready with seg_last=0: increment seg_idx, advance seg_addr, stay in EMIT.
    - On seg_valid&&seg_ready with seg_last=1: go to IDLE.
- Latency:
  - Request accepted at edge N: first descriptor valid after edge N (zero bubble).
  - Successive descriptors are back-to-back when seg_ready is held high.
  - req_ready returns high the cycle after the last descriptor handshake. There is no same-cycle re-accept.
- seg_last=1 exactly when seg_idx == full_cnt. When full_cnt=0 the first descriptor is the last.
- Stall: while seg_valid=1 and seg_ready=0, every seg_* field is held stable.
- seg_ready while seg_valid=0: ignored.
- req_valid while not in IDLE: ignored. Requests are not queued.
- Reset mid-transfer: immediately returns to IDLE with seg_valid=0. The in-flight transfer is discarded; no partial completion is signalled.
- Maximum request (req_len all ones): full_cnt = 2^(LEN_W-MAX_PLD_LOG2)-1, which fits seg_idx without overflow.

Test Plan:
- Minimum request: req_len=0, req_addr=0x1000 -> one descriptor: addr=0x1000, size=8, bytes=1, pad=7, last=1, idx=0.
- Single full segment: req_len=255 -> one descriptor: size=256, bytes=256, pad=0, last=1.
  - Checks that seg_size carries 256 without truncation.
- One full plus tail: req_len=256, req_addr=0 -> two descriptors:
  - addr 0x0: size 256, pad 0, last 0.
  - addr 0x100: size 8, bytes 1, pad 7, last 1, idx 1.
- Stalled multi-segment: req_len=0x3FF with seg_ready toggling 1,0,0,1 repeating -> four descriptors of size 256 at 0x000/0x100/0x200/0x300.
  - Fields stable during stalls; last only on idx 3; req_ready high one cycle after the final handshake.
- Tail rounding sweep: req_len=40 -> size 64, bytes 41, pad 23. Sweep req_len 0..255 against the reference model.
  - With MAX_PLD_LOG2=6: req_len=100 -> segment 64/0, then tail size 64, bytes 37, pad 27.
- Reset mid-transfer: req_len=0x2FF; assert reset after the first handshake -> seg_valid=0 and busy=0 while reset is asserted.
  - A new request req_len=7 after release -> single descriptor: size 8, pad 0, idx 0.
